// File: rtl/conv_seq_ctrl_if.sv
// Stream and filter-ROM signals of the conv_seq_ctrl sequencer.
// master: the sequencer; slave: the surrounding stream/ROM environment.
interface conv_seq_ctrl_if #(
  parameter int T  = 32,
  parameter int AW = 4
);
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] s_data;
  logic [AW-1:0]       rom_addr;
  logic signed [T-1:0] rom_data;
  logic                m_valid;
  logic                m_ready;
  logic signed [T-1:0] m_data;

  modport master (
    input  s_valid, s_data, rom_data, m_ready,
    output s_ready, rom_addr, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, rom_data, m_ready,
    input  s_ready, rom_addr, m_valid, m_data
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// 1-D convolution sequencer: buffers an N-sample frame, MACs it against an M-tap ROM
// and streams N-M+1 results. Optional macro RELU_EN clamps negative results to zero.
module conv_seq_ctrl #(
  parameter int N = 43,
  parameter int M = 16,
  parameter int T = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  conv_seq_ctrl_if.master  bus,
  output logic             busy
);
  localparam int IW = $clog2(N);
  localparam int JW = $clog2(N - M + 2);
  localparam int CW = $clog2(M + 1);
  localparam int AW = $clog2(M);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t                state;
  logic [IW-1:0]         i;
  logic [JW-1:0]         j;
  logic [CW-1:0]         c;
  logic signed [T-1:0]   x_mem [N];
  logic signed [T-1:0]   x_d;
  logic signed [2*T-1:0] x_ext, r_ext, prod, acc, acc_next;
  logic [IW-1:0]         x_idx;
  logic signed [T-1:0]   y;

  // NOTE: every signal gets a value on every pass through this block, so no latch is inferred.
  always_comb begin
    x_ext    = x_d;
    r_ext    = bus.rom_data;
    prod     = x_ext * r_ext;
    acc_next = acc + prod;
    x_idx    = IW'(j) + IW'(c);
`ifdef RELU_EN
    y = acc_next[2*T-1] ? '0 : acc_next[T-1:0];
`else
    y = acc_next[T-1:0];
`endif
  end

  // NOTE: the sample buffer has no reset; every entry is rewritten in LOAD before COMPUTE reads it.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.s_valid && bus.s_ready)
      x_mem[i] <= bus.s_data;
  end

  // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LOAD;
      i            <= '0;
      j            <= '0;
      c            <= '0;
      x_d          <= '0;
      acc          <= '0;
      bus.rom_addr <= '0;
      bus.m_valid  <= 1'b0;
      bus.m_data   <= '0;
      bus.s_ready  <= 1'b1;
      busy         <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.s_valid && bus.s_ready) begin
            if (i == IW'(N - 1)) begin
              i            <= '0;
              c            <= '0;
              bus.rom_addr <= '0;
              bus.s_ready  <= 1'b0;
              busy         <= 1'b1;
              state        <= COMPUTE;
            end else begin
              i <= i + IW'(1);
            end
          end
        end

        COMPUTE: begin
          // The x operand trails the address by one cycle to meet the registered ROM output.
          if (c < CW'(M))
            x_d <= x_mem[x_idx];
          if (c < CW'(M - 1))
            bus.rom_addr <= AW'(c) + AW'(1);
          if (c == '0)
            acc <= '0;
          else
            acc <= acc_next;
          if (c == CW'(M)) begin
            bus.m_data  <= y;
            bus.m_valid <= 1'b1;
            state       <= OUTPUT;
          end else begin
            c <= c + CW'(1);
          end
        end

        OUTPUT: begin
          if (bus.m_ready) begin
            bus.m_valid  <= 1'b0;
            c            <= '0;
            bus.rom_addr <= '0;
            if (j < JW'(N - M)) begin
              j     <= j + JW'(1);
              state <= COMPUTE;
            end else begin
              j           <= '0;
              bus.s_ready <= 1'b1;
              busy        <= 1'b0;
              state       <= LOAD;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed self-checking bench for conv_seq_ctrl with a registered coefficient ROM model.
module tb_conv_seq_ctrl;
  localparam int N  = 43;
  localparam int M  = 16;
  localparam int T  = 32;
  localparam int AW = $clog2(M);
  localparam int NR = N - M + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic busy;

  conv_seq_ctrl_if #(.T(T), .AW(AW)) bus ();

  conv_seq_ctrl #(.N(N), .M(M), .T(T)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  longint coef [M] = '{-37226, -31499, -19346, -27059, -4213, -12043, -50397, 35919,
                       -17676, -28346, -41084, -10487, -52878, -24752, 2831, 677};

  always @(posedge clk) bus.rom_data <= T'(coef[bus.rom_addr]);

  int     n_pass = 0;
  int     n_total = 0;
  int     stable_err = 0;
  int     mon_err = 0;
  bit     mon_en = 1'b0;
  longint xf [N];
  longint xa [N];
  longint xb [N];
  longint got [NR];
  longint ref_got [NR];
  longint got_a [NR];
  longint exp_a [NR];
  longint exp_b [NR];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Output stage applied to a full-width accumulator value.
  function automatic longint post(input longint a);
    int r;
    r = a[31:0];
`ifdef RELU_EN
    if (a < 0) r = 0;
`endif
    return longint'(r);
  endfunction

  function automatic longint model(input int j);
    longint acc = 0;
    for (int k = 0; k < M; k++) acc += xf[j + k] * coef[k];
    return post(acc);
  endfunction

  // Called and returns at a negedge; s_valid gaps of 0..max_gap cycles before each sample.
  task automatic send_frame(input int max_gap);
    for (int i = 0; i < N; i++) begin
      int gap;
      int t;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.s_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = T'(xf[i]);
      t = 0;
      while (!bus.s_ready && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) begin
        check("s_handshake_timeout", 0, 1);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  // Collects n results into got[]; result stall_idx is held off for stall_len cycles.
  task automatic recv_frame(input int n, input int stall_idx, input int stall_len);
    for (int k = 0; k < n; k++) begin
      int t;
      logic signed [T-1:0] d0;
      bus.m_ready = (k == stall_idx) ? 1'b0 : 1'b1;
      t = 0;
      while (!bus.m_valid && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        check("m_valid_timeout", k, n);
        bus.m_ready = 1'b1;
        return;
      end
      if (k == stall_idx) begin
        d0 = bus.m_data;
        repeat (stall_len) begin
          @(negedge clk);
          if (!bus.m_valid || bus.m_data != d0) stable_err++;
        end
        bus.m_ready = 1'b1;
      end
      got[k] = bus.m_data;
      @(posedge clk);
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
  endtask

  always @(negedge clk) if (mon_en && (bus.s_ready != !busy)) mon_err++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int stale;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 1);

    // All-ones frame with first-result latency
    for (int i = 0; i < N; i++) xf[i] = 1;
    send_frame(0);
    check("busy_after_load", busy, 1);
    check("s_ready_after_load", bus.s_ready, 0);
    lat = 1;
    while (!bus.m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("first_result_latency", lat, 18);
    recv_frame(NR, -1, 0);
    for (int k = 0; k < NR; k++) check($sformatf("ones_y%0d", k), got[k], post(-317579));
    check("s_ready_after_last_out", bus.s_ready, 1);
    check("busy_after_last_out", busy, 0);

    // Impulse at x[0]
    for (int i = 0; i < N; i++) xf[i] = (i == 0) ? 1 : 0;
    send_frame(0);
    recv_frame(NR, -1, 0);
    for (int k = 0; k < NR; k++)
      check($sformatf("imp0_y%0d", k), got[k], (k == 0) ? post(-37226) : 0);

    // Impulse at x[15]: y[j] = f[15-j]
    for (int i = 0; i < N; i++) xf[i] = (i == 15) ? 1 : 0;
    send_frame(0);
    recv_frame(NR, -1, 0);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("imp15_y%0d", k), got[k], (k <= 15) ? post(coef[15 - k]) : 0);
      ref_got[k] = got[k];
    end

    // Same frame with y[3] held off for 5 cycles
    send_frame(0);
    recv_frame(NR, 3, 5);
    check("bp_stable", stable_err, 0);
    for (int k = 0; k < NR; k++) check($sformatf("bp_y%0d", k), got[k], ref_got[k]);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.m_valid) stale++;
    end
    check("bp_no_extra_result", stale, 0);

    // Reset in the middle of COMPUTE for j=10
    for (int i = 0; i < N; i++) xf[i] = 1;
    send_frame(0);
    recv_frame(10, -1, 0);
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_rom_addr", bus.rom_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.m_valid) stale++;
    end
    check("mid_no_stale_valid", stale, 0);
    send_frame(0);
    recv_frame(NR, -1, 0);
    for (int k = 0; k < NR; k++) check($sformatf("post_rst_y%0d", k), got[k], post(-317579));

    // Two back-to-back frames with random input gaps
    for (int i = 0; i < N; i++) begin
      int h;
      xa[i] = (i % 7) * 1000 - 3000;
      h = 32'h9E3779B9;
      h = h * (i + 1);
      xb[i] = longint'(h);
    end
    for (int i = 0; i < N; i++) xf[i] = xa[i];
    for (int k = 0; k < NR; k++) exp_a[k] = model(k);
    for (int i = 0; i < N; i++) xf[i] = xb[i];
    for (int k = 0; k < NR; k++) exp_b[k] = model(k);
    for (int i = 0; i < N; i++) xf[i] = xa[i];
    mon_en = 1'b1;
    fork
      begin
        send_frame(3);
        for (int i = 0; i < N; i++) xf[i] = xb[i];
        send_frame(3);
      end
      begin
        recv_frame(NR, -1, 0);
        for (int k = 0; k < NR; k++) got_a[k] = got[k];
        recv_frame(NR, -1, 0);
      end
    join
    mon_en = 1'b0;
    check("b2b_s_ready_vs_load", mon_err, 0);
    for (int k = 0; k < NR; k++) check($sformatf("b2b_a_y%0d", k), got_a[k], exp_a[k]);
    for (int k = 0; k < NR; k++) check($sformatf("b2b_b_y%0d", k), got[k], exp_b[k]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
